// File: rtl/map9v3_sweep_pkg.sv
// rtl/map9v3_sweep_pkg.sv - shared types and widths for the map9v3 sweep controller
package map9v3_sweep_pkg;

  localparam int NW = 9;
  localparam int DW = 9;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LO,
    WAIT_HI,
    STORE,
    NEXT
  } state_e;

  typedef struct packed {
    logic [NW-1:0] n;
    logic [DW-1:0] dp;
  } result_t;

  // A zero step would never advance the sweep, so it is promoted to one.
  function automatic logic [NW-1:0] eff_step(input logic [NW-1:0] s);
    return (s == '0) ? NW'(1) : s;
  endfunction

endpackage

// File: rtl/map9v3_sweep_fifo.sv
// rtl/map9v3_sweep_fifo.sv - synchronous result FIFO with registered head entry
module map9v3_sweep_fifo
  import map9v3_sweep_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  result_t wdata_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output result_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  result_t       mem_q [DEPTH];
  result_t       head_q, head_d;
  logic [AW-1:0] rd_q, rd_d, wr_q;
  logic [CW-1:0] count_q;
  logic          do_pop, do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rd_d    = rd_q + AW'(do_pop);
  assign head_o  = head_q;

  // Head is rebuilt every cycle; a write landing in the next head slot bypasses memory.
  always_comb begin
    head_d = mem_q[rd_d];
    if (do_push && (wr_q == rd_d)) head_d = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_q + AW'(do_push);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/map9v3_sweep_ctrl.sv
// rtl/map9v3_sweep_ctrl.sv - N sweep sequencer and result collector for the map9v3 core
// Optional wait watchdog: MAP9V3_SWEEP_TIMEOUT_EN
module map9v3_sweep_ctrl
  import map9v3_sweep_pkg::*;
#(
  parameter int START_HOLD = 2,
`ifdef MAP9V3_SWEEP_TIMEOUT_EN
  parameter int TIMEOUT    = 1024,
`endif
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go_i,
  input  logic [NW-1:0] n_first_i,
  input  logic [NW-1:0] n_last_i,
  input  logic [NW-1:0] n_step_i,
  output logic          start_o,
  output logic [NW-1:0] n_o,
  input  logic [DW-1:0] dp_i,
  input  logic          done_i,
  output logic          busy_o,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [NW-1:0] res_n_o,
  output logic [DW-1:0] res_dp_o,
  output logic          timeout_err_o
);

  localparam int HW = $clog2(START_HOLD + 1);

  state_e        state_q;
  logic [NW-1:0] n_q, last_q, step_q;
  logic [HW-1:0] hold_q;
  logic          start_q, busy_q;
  logic [NW:0]   nxt;
  logic          fifo_full, fifo_empty, store_ok;
  result_t       entry, head;

  assign nxt      = {1'b0, n_q} + {1'b0, step_q};
  assign store_ok = !fifo_full || res_ready_i;
  assign entry    = '{n: n_q, dp: dp_i};

`ifdef MAP9V3_SWEEP_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0] TMAX = TCW'(TIMEOUT - 1);
  logic [TCW-1:0] tmo_q;
  logic           err_q;
  assign timeout_err_o = err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      last_q  <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MAP9V3_SWEEP_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (go_i) begin
            n_q     <= n_first_i;
            last_q  <= n_last_i;
            step_q  <= eff_step(n_step_i);
            hold_q  <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
`ifdef MAP9V3_SWEEP_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        LAUNCH: begin
          if (hold_q == HW'(START_HOLD - 1)) begin
            start_q <= 1'b0;
            state_q <= WAIT_LO;
`ifdef MAP9V3_SWEEP_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        WAIT_LO, WAIT_HI: begin
          // The counter spans both wait phases; progress wins over abort on the same edge.
          if ((state_q == WAIT_LO) && !done_i) begin
            state_q <= WAIT_HI;
          end else if ((state_q == WAIT_HI) && done_i) begin
            state_q <= STORE;
`ifdef MAP9V3_SWEEP_TIMEOUT_EN
          end else if (tmo_q >= TMAX) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`endif
          end
`ifdef MAP9V3_SWEEP_TIMEOUT_EN
          tmo_q <= tmo_q + TCW'(1);
`endif
        end
        STORE: begin
          if (store_ok) state_q <= NEXT;
        end
        NEXT: begin
          if (nxt > {1'b0, last_q}) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            n_q     <= nxt[NW-1:0];
            hold_q  <= '0;
            start_q <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  map9v3_sweep_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (state_q == STORE),
    .wdata_i (entry),
    .pop_i   (res_ready_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign start_o     = start_q;
  assign n_o         = n_q;
  assign busy_o      = busy_q;
  assign res_valid_o = !fifo_empty;
  assign res_n_o     = head.n;
  assign res_dp_o    = head.dp;

endmodule

// File: tb/tb_map9v3_sweep_ctrl.sv
// tb/tb_map9v3_sweep_ctrl.sv - directed bench for map9v3_sweep_ctrl with a behavioural core
module tb_map9v3_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       go = 1'b0;
  logic [8:0] n_first = '0, n_last = '0, n_step = '0;
  logic       start;
  logic [8:0] n;
  logic [8:0] dp_m = '0;
  logic       done_m = 1'b1;
  logic       busy, res_valid;
  logic       res_ready = 1'b1;
  logic [8:0] res_n, res_dp;
  logic       timeout_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

`ifdef MAP9V3_SWEEP_TIMEOUT_EN
  map9v3_sweep_ctrl #(.START_HOLD(2), .TIMEOUT(16), .FIFO_DEPTH(4)) dut (
`else
  map9v3_sweep_ctrl #(.START_HOLD(2), .FIFO_DEPTH(4)) dut (
`endif
    .clk           (clk),
    .rst_n         (rst_n),
    .go_i          (go),
    .n_first_i     (n_first),
    .n_last_i      (n_last),
    .n_step_i      (n_step),
    .start_o       (start),
    .n_o           (n),
    .dp_i          (dp_m),
    .done_i        (done_m),
    .busy_o        (busy),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_n_o       (res_n),
    .res_dp_o      (res_dp),
    .timeout_err_o (timeout_err)
  );

  function automatic logic [8:0] fdp(input logic [8:0] v);
    return 9'((int'(v) * 5 + 7) % 512);
  endfunction

  // Core model: start double-registered, done drops on start, rises after `delay` cycles.
  logic s1 = 1'b0, s2 = 1'b0;
  int   delay = 3;
  int   cnt = 0;
  always @(posedge clk) begin
    s1 <= start;
    s2 <= s1;
    if (s1 && !s2) begin
      done_m <= 1'b0;
      cnt    <= delay;
    end else if (!done_m && cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        done_m <= 1'b1;
        dp_m   <= fdp(n);
      end
    end
  end

  logic [8:0] got_n[$];
  logic [8:0] got_dp[$];
  int start_rise = 0;
  int start_hi = 0;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      got_n.push_back(res_n);
      got_dp.push_back(res_dp);
    end
    if (start && !start_prev) start_rise++;
    if (start) start_hi++;
    start_prev = start;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [8:0] f, input logic [8:0] l, input logic [8:0] s);
    n_first = f;
    n_last  = l;
    n_step  = s;
    go      = 1'b1;
    @(posedge clk);
    #1;
    go      = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy && i < 4000) begin
      @(negedge clk);
      i++;
    end
    check(tag, busy, 0);
    tick(3);
  endtask

  task automatic check_entries(input string tag, input int base, input int first,
                               input int step, input int k);
    check({tag, "_count"}, got_n.size() - base, k);
    for (int i = 0; i < k; i++) begin
      if (base + i < got_n.size()) begin
        check($sformatf("%s_n%0d", tag, i), got_n[base+i], first + i * step);
        check($sformatf("%s_dp%0d", tag, i), got_dp[base+i], fdp(9'(first + i * step)));
      end
    end
  endtask

  initial begin
    int base, r0, h0, k;
    #2 rst_n = 1'b0;
    tick(3);
    check("rst_start", start, 0);
    check("rst_n", n, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_err", timeout_err, 0);
    rst_n = 1'b1;
    tick(2);

    // 3..9 step 3
    base = got_n.size(); r0 = start_rise;
    launch(9'd3, 9'd9, 9'd3);
    check("t1_start_lat", start, 1);
    check("t1_busy", busy, 1);
    wait_idle("t1_idle");
    check_entries("t1", base, 3, 3, 3);
    check("t1_starts", start_rise - r0, 3);

    // first > last: single point, one start pulse two cycles wide
    base = got_n.size(); r0 = start_rise; h0 = start_hi;
    launch(9'd5, 9'd2, 9'd1);
    wait_idle("t2_idle");
    check_entries("t2", base, 5, 1, 1);
    check("t2_starts", start_rise - r0, 1);
    check("t2_start_hi", start_hi - h0, 2);

    // zero step acts as one
    base = got_n.size();
    launch(9'd10, 9'd12, 9'd0);
    wait_idle("t3_idle");
    check_entries("t3", base, 10, 1, 3);

    // 508+4 overflows 9 bits: must stop, not wrap
    base = got_n.size();
    launch(9'd508, 9'd511, 9'd4);
    wait_idle("t4_idle");
    check_entries("t4", base, 508, 4, 1);

    // backpressure: 6 points into a 4-deep FIFO
    res_ready = 1'b0;
    base = got_n.size(); r0 = start_rise;
    launch(9'd1, 9'd6, 9'd1);
    tick(300);
    check("t5_stall_starts", start_rise - r0, 5);
    check("t5_stall_busy", busy, 1);
    check("t5_stall_valid", res_valid, 1);
    check("t5_stall_head", res_n, 1);
    check("t5_stall_pops", got_n.size() - base, 0);
    res_ready = 1'b1;
    wait_idle("t5_idle");
    check_entries("t5", base, 1, 1, 6);

    // park two entries, then abort / reset with the core never finishing
    res_ready = 1'b0;
    base = got_n.size();
    launch(9'd20, 9'd21, 9'd1);
    wait_idle("t6_fill_idle");
    check("t6_fill_valid", res_valid, 1);
    check("t6_fill_head", res_n, 20);
    delay = -1;
`ifdef MAP9V3_SWEEP_TIMEOUT_EN
    launch(9'd30, 9'd30, 9'd1);
    k = 0;
    while (start && k < 50) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!timeout_err && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t6_tmo_cycles", k, 16);
    check("t6_tmo_err", timeout_err, 1);
    check("t6_tmo_busy", busy, 0);
    check("t6_tmo_valid", res_valid, 1);
    check("t6_tmo_head", res_n, 20);
    launch(9'd31, 9'd31, 9'd1);
    check("t6_err_clr", timeout_err, 0);
    check("t6_relaunch", start, 1);
`else
    launch(9'd30, 9'd30, 9'd1);
    check("t6_err_tied", timeout_err, 0);
    check("t6_relaunch", start, 1);
`endif
    tick(5);
    check("t6_mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_start", start, 0);
    check("t6_rst_n", n, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", res_valid, 0);
    check("t6_rst_err", timeout_err, 0);
    check("t6_no_pops", got_n.size() - base, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("t6_post_valid", res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
